// File: rtl/trig_sched_if.sv
// Trigger/engine signal bundle for trig_sched.
// master = the scheduler, slave = trigger sources plus acquisition engine.
interface trig_sched_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   trig_in;
  logic [N-1:0]   enable;
  logic           done;
  logic           clear_overrun;
  logic           start;
  logic [IDW-1:0] start_id;
  logic           busy;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;

  modport master (
    input  trig_in, enable, done, clear_overrun,
    output start, start_id, busy, pending, overrun
  );

  modport slave (
    output trig_in, enable, done, clear_overrun,
    input  start, start_id, busy, pending, overrun
  );
endinterface

// File: rtl/trig_sched.sv
// Edge-triggered request scheduler: latches trigger edges as pending requests and
// serves them round-robin to a single engine with start/done and post-done holdoff.
module trig_sched #(
  parameter int N       = 4,
  parameter bit EDGE    = 1'b1,
  parameter int HOLDOFF = 16
) (
  input  logic         clk,
  input  logic         rst,
  trig_sched_if.master bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_HOLD} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   trig_d_reg;
  logic [N-1:0]   pending_reg, pending_next;
  logic [N-1:0]   overrun_reg, overrun_next;
  logic [N-1:0]   edge_det;
  logic [N-1:0]   grant_vec;
  logic [IDW-1:0] start_id_reg, start_id_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [IDW-1:0] winner;
  logic           winner_valid;
  logic [7:0]     cnt_reg, cnt_next;

  // Loaded during reset too, so a level held across reset never looks like an edge.
  always_ff @(posedge clk) begin
    trig_d_reg <= bus.trig_in;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign edge_det[gi] = EDGE ? (bus.trig_in[gi] & ~trig_d_reg[gi])
                                 : (~bus.trig_in[gi] & trig_d_reg[gi]);
      // A fresh edge in the grant cycle re-arms the request instead of overrunning.
      assign pending_next[gi] = bus.enable[gi] &
                                (edge_det[gi] | (pending_reg[gi] & ~grant_vec[gi]));
      assign overrun_next[gi] = (edge_det[gi] & bus.enable[gi] & pending_reg[gi] & ~grant_vec[gi])
                              | (overrun_reg[gi] & ~bus.clear_overrun);
    end
  endgenerate

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    winner       = '0;
    winner_valid = 1'b0;
    idx          = 0;
    idx_w        = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last_reg) + k) % N;
      idx_w = IDW'(idx);
      if (!winner_valid && pending_reg[idx_w]) begin
        winner       = idx_w;
        winner_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    start_id_next = start_id_reg;
    last_next     = last_reg;
    grant_vec     = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (winner_valid) begin
          grant_vec[winner] = 1'b1;
          start_id_next     = winner;
          last_next         = winner;
          state_next        = ST_START;
        end
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.done) begin
          if (HOLDOFF == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_HOLD;
            cnt_next   = 8'(HOLDOFF - 1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pending_reg  <= '0;
      overrun_reg  <= '0;
      start_id_reg <= '0;
      last_reg     <= IDW'(N - 1);
      cnt_reg      <= 8'd0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
      start_id_reg <= start_id_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign bus.start    = (state_reg == ST_START);
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.start_id = start_id_reg;
  assign bus.pending  = pending_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched: rising-edge unit with HOLDOFF=4 and
// falling-edge unit with HOLDOFF=0.
module tb_trig_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  trig_sched_if #(.N(4)) bus();
  trig_sched_if #(.N(4)) bus_f();

  trig_sched #(.N(4), .EDGE(1'b1), .HOLDOFF(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  trig_sched #(.N(4), .EDGE(1'b0), .HOLDOFF(0)) dut_f (
    .clk(clk), .rst(rst), .bus(bus_f.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    bus.trig_in   = 4'b1111;
    bus_f.trig_in = 4'b1111;
    do_reset();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", bus.start); end
    checks++; if (bus.start_id !== 2'd0) begin failures++; $display("FAIL rst_start_id got=%0d exp=0", bus.start_id); end
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL rst_pending got=%b exp=0000", bus.pending); end
    checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL rst_overrun got=%b exp=0000", bus.overrun); end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.start || bus.pending != 4'b0000 || bus_f.start || bus_f.pending != 4'b0000) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL held_high_no_req got=%b exp=0", seen); end
    bus.trig_in = 4'b0000;
    tick();
    tick();
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL fall_ignored got=%b exp=0000", bus.pending); end
    $display("test_reset done");
  endtask

  task automatic test_single_edge();
    bus.trig_in = 4'b0100;
    tick();
    bus.trig_in = 4'b0000;
    checks++; if (bus.pending !== 4'b0100) begin failures++; $display("FAIL single_pending got=%b exp=0100", bus.pending); end
    checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL single_early_start got=%b exp=0", bus.start); end
    tick();
    checks++; if (bus.start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", bus.start); end
    checks++; if (bus.start_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", bus.start_id); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL single_pending_clr got=%b exp=0000", bus.pending); end
    tick();
    checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", bus.start); end
    repeat (5) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_busy_d4 got=%b exp=1", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_release_d5 got=%b exp=0", bus.busy); end
    $display("test_single_edge done");
  endtask

  task automatic test_round_robin();
    int exp_ids[7] = '{0, 1, 3, 0, 1, 2, 3};
    bit got;
    do_reset();
    bus.trig_in = 4'b1011;
    tick();
    bus.trig_in = 4'b0000;
    for (int n = 0; n < 7; n++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        if (bus.start) got = 1'b1;
        else tick();
      end
      checks++;
      if (!got) begin
        failures++; $display("FAIL rr_timeout grant=%0d got=none exp=%0d", n, exp_ids[n]);
      end else if (bus.start_id !== 2'(exp_ids[n])) begin
        failures++; $display("FAIL rr_order grant=%0d got=%0d exp=%0d", n, bus.start_id, exp_ids[n]);
      end
      $display("rr grant %0d id=%0d", n, bus.start_id);
      if (n == 2) begin
        bus.trig_in = 4'b1111;
        tick();
        bus.trig_in = 4'b0000;
        checks++; if (bus.pending !== 4'b1111) begin failures++; $display("FAIL rr_all_pending got=%b exp=1111", bus.pending); end
      end else begin
        tick();
      end
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    repeat (6) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_end_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_overrun();
    bit got;
    bus.trig_in = 4'b0001;
    tick();
    bus.trig_in = 4'b0000;
    tick();
    checks++; if (bus.start !== 1'b1 || bus.start_id !== 2'd0) begin failures++; $display("FAIL ovr_start0 got=%b/%0d exp=1/0", bus.start, bus.start_id); end
    bus.trig_in = 4'b0010;
    tick();
    bus.trig_in = 4'b0000;
    tick();
    bus.trig_in = 4'b0010;
    tick();
    bus.trig_in = 4'b0000;
    checks++; if (bus.overrun !== 4'b0010) begin failures++; $display("FAIL ovr_set got=%b exp=0010", bus.overrun); end
    checks++; if (bus.pending !== 4'b0010) begin failures++; $display("FAIL ovr_pending got=%b exp=0010", bus.pending); end
    tick();
    bus.trig_in = 4'b0010;
    bus.clear_overrun = 1'b1;
    tick();
    bus.trig_in = 4'b0000;
    bus.clear_overrun = 1'b0;
    checks++; if (bus.overrun !== 4'b0010) begin failures++; $display("FAIL ovr_set_wins got=%b exp=0010", bus.overrun); end
    bus.clear_overrun = 1'b1;
    tick();
    bus.clear_overrun = 1'b0;
    checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL ovr_clear got=%b exp=0000", bus.overrun); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bus.start) got = 1'b1;
      else tick();
    end
    checks++; if (!got || bus.start_id !== 2'd1) begin failures++; $display("FAIL ovr_serve1 got=%b/%0d exp=1/1", got, bus.start_id); end
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    repeat (6) tick();
    $display("test_overrun done");
  endtask

  task automatic test_enable_clear();
    bit seen;
    bus.trig_in = 4'b0001;
    tick();
    bus.trig_in = 4'b0000;
    tick();
    checks++; if (bus.start !== 1'b1 || bus.start_id !== 2'd0) begin failures++; $display("FAIL en_start0 got=%b/%0d exp=1/0", bus.start, bus.start_id); end
    tick();
    bus.trig_in = 4'b1000;
    tick();
    bus.trig_in = 4'b0000;
    checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL en_pending3 got=%b exp=1000", bus.pending); end
    bus.enable = 4'b0111;
    tick();
    bus.enable = 4'b1111;
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL en_cleared got=%b exp=0000", bus.pending); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.start) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL en_no_start got=%b exp=0", seen); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin failures++; $display("FAIL idle_done_ignored got=%b/%b exp=0/0", bus.busy, bus.start); end
    $display("test_enable_clear done");
  endtask

  task automatic test_falling_edge();
    bus_f.trig_in = 4'b1110;
    tick();
    checks++; if (bus_f.pending !== 4'b0001) begin failures++; $display("FAIL fall_pending got=%b exp=0001", bus_f.pending); end
    tick();
    checks++; if (bus_f.start !== 1'b1 || bus_f.start_id !== 2'd0) begin failures++; $display("FAIL fall_start got=%b/%0d exp=1/0", bus_f.start, bus_f.start_id); end
    tick();
    bus_f.done = 1'b1;
    tick();
    bus_f.done = 1'b0;
    checks++; if (bus_f.busy !== 1'b0) begin failures++; $display("FAIL fall_no_hold got=%b exp=0", bus_f.busy); end
    bus_f.trig_in = 4'b1111;
    tick();
    tick();
    checks++; if (bus_f.start !== 1'b0 || bus_f.pending !== 4'b0000) begin failures++; $display("FAIL fall_rise_ignored got=%b/%b exp=0/0000", bus_f.start, bus_f.pending); end
    $display("test_falling_edge done");
  endtask

  task automatic test_reset_mid();
    bus.trig_in = 4'b0001;
    tick();
    bus.trig_in = 4'b0000;
    tick();
    tick();
    bus.trig_in = 4'b1010;
    tick();
    bus.trig_in = 4'b0000;
    checks++; if (bus.pending !== 4'b1010 || bus.busy !== 1'b1) begin failures++; $display("FAIL mid_setup got=%b/%b exp=1010/1", bus.pending, bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL mid_pending got=%b exp=0000", bus.pending); end
    checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL mid_start got=%b exp=0", bus.start); end
    tick();
    checks++; if (bus.start !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mid_no_reissue got=%b/%b exp=0/0", bus.start, bus.busy); end
    bus.trig_in = 4'b0001;
    tick();
    bus.trig_in = 4'b0000;
    tick();
    checks++; if (bus.start !== 1'b1 || bus.start_id !== 2'd0) begin failures++; $display("FAIL mid_regrant got=%b/%0d exp=1/0", bus.start, bus.start_id); end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst                 = 1'b1;
    bus.trig_in         = 4'b0000;
    bus.enable          = 4'b1111;
    bus.done            = 1'b0;
    bus.clear_overrun   = 1'b0;
    bus_f.trig_in       = 4'b1111;
    bus_f.enable        = 4'b1111;
    bus_f.done          = 1'b0;
    bus_f.clear_overrun = 1'b0;
    test_reset();
    test_single_edge();
    test_round_robin();
    test_overrun();
    test_enable_clear();
    test_falling_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trig_sched.md
# trig_sched

Edge-triggered request scheduler for a single shared acquisition engine. Detects a configurable edge on each of N trigger inputs, latches each detected edge as a pending request, and grants requests one at a time in round-robin order using a start/done handshake. Sits between synchronous trigger sources and the engine, enforcing a minimum holdoff between engine runs and flagging lost triggers.

## Interface
- N, 4, number of trigger channels (2..16)
- EDGE, 1, detected edge on all channels: 1 rising, 0 falling
- HOLDOFF, 16, idle cycles forced after each done (0..255; 0 = none)

- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- trig_in  in  N  trigger levels, already synchronous to clk
- enable  in  N  per-channel enable; a low bit masks and clears that channel
- done  in  1  engine finished; single-cycle pulse, sampled only in WAIT
- clear_overrun  in  1  clears all overrun bits
- start  out  1  one-cycle pulse launching the engine
- start_id  out  clog2(N)  channel being served; held from START until the next grant
- busy  out  1  high in START, WAIT and HOLD
- pending  out  N  latched, ungranted requests
- overrun  out  N  sticky: edge arrived while the channel was already pending

## Operation
- Per-channel edge: trig_d <= trig_in every cycle. edge[i] = trig_in[i] & ~trig_d[i] (EDGE=1) or ~trig_in[i] & trig_d[i] (EDGE=0).
- During rst, trig_d loads trig_in, so leaving reset never produces a spurious edge.
- pending[i] next value:
  - edge[i] & enable[i] sets it.
  - A grant to channel i clears it.
  - enable[i]=0 clears it; this wins over set.
  - Grant and new edge on the same channel in the same cycle: pending stays 1, no overrun.
- overrun[i] sets when edge[i] & enable[i] & pending[i] and channel i is not being granted that cycle. clear_overrun clears all bits; a set in the same cycle wins.
- Round-robin pointer last holds the most recently granted id. Search order is last+1, last+2, ... wrapping modulo N. The first pending bit found wins.
- FSM states and transitions:
  - IDLE: if any pending bit is set, latch winner into start_id and last, clear its pending bit, go to START.
  - START: start=1 for exactly one cycle, go to WAIT.
  - WAIT: stay until done=1. Then go to HOLD with cnt=HOLDOFF-1, or straight to IDLE if HOLDOFF=0.
  - HOLD: decrement cnt; at cnt=0 go to IDLE. Pending requests keep accumulating during HOLD.
- A done pulse outside WAIT is ignored. There is no engine timeout.
- Reset values: state IDLE, start 0, start_id 0, busy 0, pending 0, overrun 0, last N-1 (channel 0 is searched first), cnt 0.
- Reset asserted mid-operation: return to IDLE at the next edge. All pending requests and overrun flags are discarded; start is not re-issued.

## Timing
- Edge present in cycle T (trig_in changed before edge T, trig_d still old): pending visible in cycle T+1.
- The IDLE grant happens at the end of cycle T+1: start_id and busy valid in T+2, start=1 in T+2.
- Minimum edge-to-start latency: 2 cycles. busy rises together with start.
- Done sampled in cycle D with HOLDOFF=H>0: HOLD occupies D+1..D+H, IDLE at D+H+1. The next start comes at the earliest in D+H+2.
- With HOLDOFF=0: IDLE in D+1, next start in D+2.
- Edge-to-pending and grant-to-pending-clear are each one cycle. overrun updates in the cycle after the offending edge.

## Test plan
- Single rising edge on ch2 at cycle 10 (EDGE=1): pending=0100 at 11; start=1 with start_id=2 at 12; done at 20 with HOLDOFF=4 -> busy low at 25.
- Edges on ch0, ch1 and ch3 in the same cycle: starts issued in order id 0, 1, 3. Second round with all four pending and last=3 -> order 0, 1, 2, 3.
- Two ch1 edges while ch1 is pending and ungranted -> overrun=0010. clear_overrun asserted in the same cycle as a third edge -> overrun stays 0010. clear_overrun alone -> 0000.
- trig_in held high through rst and after reset release -> no pending and no start. EDGE=0 with a falling edge on ch0 -> start id 0 after 2 cycles.
- ch3 pending with enable[3] dropped for one cycle -> pending[3]=0 and no start. done pulsed while IDLE -> state unchanged.
- rst asserted in WAIT with pending=1010 -> next cycle: busy 0, pending 0000, start 0. After release, a new ch0 edge is granted first.
